// File: rtl/uart_tx.sv
// 8N1 UART transmitter that drains a first-word-fall-through FIFO and
// serializes each popped word LSB first on a registered tx line.
module uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int BCNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIDX_W = $clog2(DATA_WIDTH);

   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]            state;
   logic [BCNT_W-1:0]     bcnt;
   logic [BIDX_W-1:0]     bidx;
   logic [DATA_WIDTH-1:0] shift;
   logic                  bit_end;
   logic                  pop;

   assign bit_end = (bcnt == BCNT_LAST);

   // A pop in the last stop cycle chains the next frame with no idle gap.
   assign pop = tx_en && !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && bit_end));

   assign fifo_rd_en = pop && !rst;
   assign done       = (state == STOP) && bit_end && !rst;
   assign busy       = (state != IDLE);

   // tx is loaded with the level of the state being entered so it stays
   // aligned with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bcnt  <= '0;
         bidx  <= '0;
         shift <= '0;
         tx    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bcnt <= '0;
               if (pop) begin
                  shift <= fifo_dout;
                  state <= START;
                  tx    <= 1'b0;
               end else begin
                  tx    <= 1'b1;
               end
            end

            START: begin
               if (bit_end) begin
                  bcnt  <= '0;
                  bidx  <= '0;
                  state <= DATA;
                  tx    <= shift[0];
               end else begin
                  bcnt  <= bcnt + BCNT_W'(1);
               end
            end

            DATA: begin
               if (bit_end) begin
                  bcnt  <= '0;
                  shift <= shift >> 1;
                  if (bidx == BIDX_LAST) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bidx  <= bidx + BIDX_W'(1);
                     tx    <= shift[1];
                  end
               end else begin
                  bcnt  <= bcnt + BCNT_W'(1);
               end
            end

            STOP: begin
               if (bit_end) begin
                  bcnt <= '0;
                  if (pop) begin
                     shift <= fifo_dout;
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  bcnt <= bcnt + BCNT_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               bcnt  <= '0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that drains a byte-wide FIFO and serializes each byte as an 8N1 frame on a single output line. It is the consuming end of the CPU's output FIFO: the core writes bytes into the FIFO, and this block pops and transmits them. It also works as a generic FIFO-to-serial drain for any first-word-fall-through FIFO in the design.

## Interface
- `DATA_WIDTH`, 8, data bits per frame; sent LSB first.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥ 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tx_en` input 1: when high, the block may start new frames; a frame already in flight always completes.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_dout` input DATA_WIDTH: FIFO head word. First-word-fall-through, so it is valid whenever `fifo_empty` is 0.
- `fifo_rd_en` output 1: pop strobe to the FIFO; one-cycle pulse per byte.
- `tx` output 1: serial line; idles high; registered.
- `busy` output 1: high while a frame is in flight (any state except IDLE).
- `done` output 1: one-cycle pulse on the last cycle of each stop bit.

## Operation
- **States:**
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = `shift[0]`.
  - STOP: `tx`=1.
- **Baud counter:** `bcnt` is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 in every non-IDLE state, clears on each state or bit change, and wraps to 0 without overflow.
- **Bit index:** `bidx` is $clog2(DATA_WIDTH) bits wide and counts data bits 0..DATA_WIDTH-1.
- **Pop condition:** `pop` = `tx_en` & !`fifo_empty` & (state==IDLE | (state==STOP & `bcnt`==CLKS_PER_BIT-1)).
  - `fifo_rd_en` = `pop`, combinational (Mealy). It is never asserted while `rst`=1.
  - On a `pop` edge: `shift` <= `fifo_dout`, state <= START, `bcnt` <= 0.
- **START:** lasts CLKS_PER_BIT cycles, then DATA with `bidx`=0.
- **DATA:** at the end of each bit period, `shift` shifts right by 1 and `bidx` increments. After bit DATA_WIDTH-1, go to STOP.
- **STOP:** lasts CLKS_PER_BIT cycles. On its last cycle, `done`=1. The next state is START if `pop`, else IDLE.
- **Back-to-back frames:** there are no idle cycles between frames while the FIFO is non-empty and `tx_en`=1.
- **`tx_en` deasserted mid-frame:** the current frame completes, then the block goes to IDLE. No further pop happens until `tx_en` returns high.
- **`fifo_empty` rising mid-frame:** no effect on the current frame.
- **`fifo_dout`:** sampled only on a `pop` edge; ignored at all other times.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `done`=0, `fifo_rd_en`=0, state=IDLE, `bcnt`=0, `bidx`=0, `shift`=0.
- **Reset mid-frame:** the frame is abandoned and the popped byte is lost. `tx`=1 from the first edge with `rst` sampled high.
- **Start latency:** with `fifo_empty` low at cycle N while in IDLE with `tx_en`=1:
  - `fifo_rd_en`=1 in cycle N.
  - `tx` falls at edge N+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles, measured from the `tx` falling edge to the end of the stop bit.
- **`busy`:** high from edge N+1 until the edge after the last stop cycle, unless a new pop occurs on that cycle.
- **Bit placement:** `tx` is registered with the state, so each bit is stable for exactly CLKS_PER_BIT cycles. Data bit k occupies cycles [(1+k)·CLKS_PER_BIT, (2+k)·CLKS_PER_BIT) after the start edge.
- **`done`:** exactly once per frame, coincident with any chained `fifo_rd_en`.
- **FIFO protocol:** at most one `fifo_rd_en` pulse per frame. Never asserted when `fifo_empty`=1.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8.
- **Reset:** hold `rst` for 3 cycles with the FIFO non-empty → `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout reset.
- **Single byte:** FIFO holds 0xA5, `tx_en`=1 →
  - one `fifo_rd_en` pulse.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total.
  - `done` pulses once.
  - `busy` returns to 0.
- **Back-to-back:** FIFO holds 0x00 then 0xFF →
  - the second `fifo_rd_en` coincides with the first `done`.
  - `tx` is high for only the 4-cycle stop bit between the two frames.
  - 80 cycles total; the FIFO ends empty.
- **`tx_en` gating:** deassert `tx_en` during frame 1 with 2 bytes queued →
  - frame 1 completes.
  - no pop until `tx_en` reasserts.
  - then frame 2 starts one cycle later.
- **Reset mid-frame:** assert `rst` during data bit 3 →
  - `tx`=1 on the next edge.
  - after release, the next queued byte transmits correctly.
  - the aborted byte is not resent.
- **Empty FIFO:** `fifo_empty`=1 with `fifo_dout` toggling for 100 cycles → no `fifo_rd_en`, `tx` constantly 1, `busy`=0.
